// File: rtl/max_unpool_stream.sv
// Max-unpooling stream: scatters pooled values back to their argmax position in each window, zero elsewhere.
// Optional MAX_UNPOOL_IDX_CHECK_EN adds a sticky idx_err flag for out-of-range window indices.
module max_unpool_stream #(
    parameter int input_size   = 8,
    parameter int pooling_size = 2,
    parameter int data_width   = 32,
    localparam int IDX_W = (pooling_size * pooling_size > 2) ? $clog2(pooling_size * pooling_size) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [data_width-1:0] in_data,
    input  logic [IDX_W-1:0]      in_idx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] out_data,
`ifdef MAX_UNPOOL_IDX_CHECK_EN
    output logic                  idx_err,
`endif
    output logic                  out_last
);

    localparam int P  = input_size / pooling_size;
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam int CW = (input_size > 1) ? $clog2(input_size) : 1;
    localparam int RW = (pooling_size > 1) ? $clog2(pooling_size) : 1;

    if (input_size % pooling_size != 0) begin : g_bad_size
        $error("max_unpool_stream: input_size must be divisible by pooling_size");
    end
    if (pooling_size < 2) begin : g_bad_pool
        $error("max_unpool_stream: pooling_size must be at least 2");
    end

    typedef enum logic {
        FILL,
        EMIT
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   fillCnt_q, fillCnt_d;
    logic [PW-1:0]   bandCnt_q, bandCnt_d;
    logic [RW-1:0]   r_q, r_d;
    logic [CW-1:0]   c_q, c_d;

    logic [data_width-1:0] bufData_q [P];
    logic [IDX_W-1:0]      bufIdx_q  [P];

    logic          inAccept;
    logic          outAccept;
    logic          colEnd;
    logic          rowEnd;
    logic          match;
    logic [PW-1:0] winSel;

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == EMIT);
    assign inAccept  = in_valid && in_ready;
    assign outAccept = out_valid && out_ready;
    assign colEnd    = (c_q == CW'(input_size - 1));
    assign rowEnd    = (r_q == RW'(pooling_size - 1));

    // Each output column maps to one buffered window; only the argmax slot carries data.
    assign winSel   = PW'(int'(c_q) / pooling_size);
    assign match    = ((int'(r_q) * pooling_size + int'(c_q) % pooling_size) == int'(bufIdx_q[winSel]));
    assign out_data = (out_valid && match) ? bufData_q[winSel] : '0;
    assign out_last = out_valid && (bandCnt_q == PW'(P - 1)) && rowEnd && colEnd;

    always_comb begin
        state_d   = state_q;
        fillCnt_d = fillCnt_q;
        bandCnt_d = bandCnt_q;
        r_d       = r_q;
        c_d       = c_q;
        case (state_q)
            FILL: begin
                if (inAccept) begin
                    if (fillCnt_q == PW'(P - 1)) begin
                        fillCnt_d = '0;
                        r_d       = '0;
                        c_d       = '0;
                        state_d   = EMIT;
                    end else begin
                        fillCnt_d = fillCnt_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (outAccept) begin
                    if (colEnd) begin
                        c_d = '0;
                        if (rowEnd) begin
                            r_d       = '0;
                            state_d   = FILL;
                            bandCnt_d = (bandCnt_q == PW'(P - 1)) ? '0 : bandCnt_q + 1'b1;
                        end else begin
                            r_d = r_q + 1'b1;
                        end
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            fillCnt_q <= '0;
            bandCnt_q <= '0;
            r_q       <= '0;
            c_q       <= '0;
        end else begin
            state_q   <= state_d;
            fillCnt_q <= fillCnt_d;
            bandCnt_q <= bandCnt_d;
            r_q       <= r_d;
            c_q       <= c_d;
        end
    end

    // Band buffer is never read outside EMIT, so it needs no reset.
    always_ff @(posedge clk) begin
        if (inAccept) begin
            bufData_q[fillCnt_q] <= in_data;
            bufIdx_q[fillCnt_q]  <= in_idx;
        end
    end

`ifdef MAX_UNPOOL_IDX_CHECK_EN
    logic idxErr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            idxErr_q <= 1'b0;
        end else if (inAccept && (int'(in_idx) >= pooling_size * pooling_size)) begin
            idxErr_q <= 1'b1;
        end
    end

    assign idx_err = idxErr_q;
`endif

endmodule
